// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: PC-source encodings, IF/ID payload and defaults.
package instruction_fetch_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
    localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0000;

    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_EXC    = 3'd4
    } pcsrc_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Hazard/redirect inputs, instruction-memory port, IF/ID outputs and perf counters of the fetch stage.
interface instruction_fetch_stage_if #(
    parameter int unsigned CNT_W = instruction_fetch_stage_pkg::CNT_W_DEFAULT
);
    logic             PCWrite;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic [2:0]       ID_PCSrc;
    logic [2:0]       EX_PCSrc;
    logic             EX_ALUOut_0;
    logic [31:0]      EX_BranchTarget;
    logic [31:0]      ID_JumpTarget;
    logic [31:0]      ID_JrTarget;
    logic [31:0]      Instruction;
    logic             perf_clear;
    logic [31:0]      IF_PC;
    logic [31:0]      IF_ID_Instruction;
    logic [31:0]      IF_ID_PC_plus_4;
    logic             IF_ID_valid;
    logic             IF_misaligned;
    logic [CNT_W-1:0] perf_fetch_cnt;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport master (
        output PCWrite, IF_ID_write, IF_ID_flush, ID_PCSrc, EX_PCSrc, EX_ALUOut_0,
               EX_BranchTarget, ID_JumpTarget, ID_JrTarget, Instruction, perf_clear,
        input  IF_PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_valid, IF_misaligned,
               perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  PCWrite, IF_ID_write, IF_ID_flush, ID_PCSrc, EX_PCSrc, EX_ALUOut_0,
               EX_BranchTarget, ID_JumpTarget, ID_JrTarget, Instruction, perf_clear,
        output IF_PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_valid, IF_misaligned,
               perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble and wins over hold; same pattern serves ID/EX.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   write,
    input  if_id_t load,
    output if_id_t q
);

    if_id_t entry_d;
    if_id_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d = '{instr: NOP_INSTR, pc_plus_4: '0, valid: 1'b0};
        end else if (write) begin
            entry_d = load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '{instr: NOP_INSTR, pc_plus_4: '0, valid: 1'b0};
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, prioritized next-PC select, IF/ID register and perf counters.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_stage_if.slave bus
);

    logic [31:0]      pc_d, pc_q;
    logic             misaligned_d, misaligned_q;
    logic [CNT_W-1:0] fetch_cnt_d, fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic [31:0]      pc_plus_4;
    logic [31:0]      next_pc;
    logic             redirect;
    logic             fetch_load;
    if_id_t           fetch_entry;
    if_id_t           if_id_q;

    assign pc_plus_4 = pc_q + 32'd4;

    // A taken EX branch squashes the younger ID instruction, so it beats any ID redirect.
    always_comb begin
        next_pc  = pc_plus_4;
        redirect = 1'b0;
        if (bus.EX_PCSrc == 3'(PCSRC_BRANCH) && bus.EX_ALUOut_0) begin
            next_pc  = bus.EX_BranchTarget;
            redirect = 1'b1;
        end else if (bus.ID_PCSrc == 3'(PCSRC_JUMP)) begin
            next_pc  = bus.ID_JumpTarget;
            redirect = 1'b1;
        end else if (bus.ID_PCSrc == 3'(PCSRC_JR)) begin
            next_pc  = bus.ID_JrTarget;
            redirect = 1'b1;
        end else if (bus.ID_PCSrc >= 3'(PCSRC_EXC)) begin
            next_pc  = EXC_VECTOR;
            redirect = 1'b1;
        end
    end

    // A stalled redirect is simply not taken; the hazard unit re-presents it next cycle.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (bus.PCWrite) begin
            pc_d         = word_align(next_pc);
            misaligned_d = redirect && (next_pc[1:0] != 2'b00);
        end
    end

    assign fetch_load = bus.IF_ID_write && !bus.IF_ID_flush;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.perf_clear) begin
            fetch_cnt_d = '0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (fetch_load)       fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            if (!bus.PCWrite)     stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (bus.IF_ID_flush)  flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign fetch_entry = '{instr: bus.Instruction, pc_plus_4: pc_plus_4, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (bus.IF_ID_flush),
        .write (bus.IF_ID_write),
        .load  (fetch_entry),
        .q     (if_id_q)
    );

    assign bus.IF_PC             = pc_q;
    assign bus.IF_ID_Instruction = if_id_q.instr;
    assign bus.IF_ID_PC_plus_4   = if_id_q.pc_plus_4;
    assign bus.IF_ID_valid       = if_id_q.valid;
    assign bus.IF_misaligned     = misaligned_q;
    assign bus.perf_fetch_cnt    = fetch_cnt_q;
    assign bus.perf_stall_cnt    = stall_cnt_q;
    assign bus.perf_flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: vector table through a scoreboard plus reset/wrap sequences.
module tb_instruction_fetch_stage;

    localparam int unsigned TB_CNT_W = 8;

    typedef struct {
        logic        pcw, ifw, fl, clr;
        logic [2:0]  id_src;
        logic [31:0] id_tgt;
        logic [2:0]  ex_src;
        logic        ex_alu;
        logic [31:0] ex_tgt;
        logic [31:0] e_pc, e_ia, e_pp4;
        logic        e_valid, e_mis;
        int          e_f, e_s, e_fl;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb_q[$];

    instruction_fetch_stage_if #(.CNT_W(TB_CNT_W)) bus_if ();

    instruction_fetch_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return addr ^ 32'h3C1D_0000;
    endfunction

    assign bus_if.Instruction = imem(bus_if.IF_PC);

    function automatic vec_t v(input logic pcw, ifw, fl, clr, input logic [2:0] id_src,
                               input logic [31:0] id_tgt, input logic [2:0] ex_src,
                               input logic ex_alu, input logic [31:0] ex_tgt,
                               input logic [31:0] e_pc, e_ia, e_pp4, input logic e_valid, e_mis,
                               input int e_f, e_s, e_fl);
        vec_t r;
        r.pcw = pcw; r.ifw = ifw; r.fl = fl; r.clr = clr;
        r.id_src = id_src; r.id_tgt = id_tgt; r.ex_src = ex_src; r.ex_alu = ex_alu; r.ex_tgt = ex_tgt;
        r.e_pc = e_pc; r.e_ia = e_ia; r.e_pp4 = e_pp4; r.e_valid = e_valid; r.e_mis = e_mis;
        r.e_f = e_f; r.e_s = e_s; r.e_fl = e_fl;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Distinct decoy targets expose a jump/jr mux swap.
    task automatic apply(input vec_t r);
        bus_if.PCWrite         = r.pcw;
        bus_if.IF_ID_write     = r.ifw;
        bus_if.IF_ID_flush     = r.fl;
        bus_if.perf_clear      = r.clr;
        bus_if.ID_PCSrc        = r.id_src;
        bus_if.ID_JumpTarget   = (r.id_src == 3'd2) ? r.id_tgt : 32'h0BAD_0000;
        bus_if.ID_JrTarget     = (r.id_src == 3'd3) ? r.id_tgt : 32'h0DAD_0000;
        bus_if.EX_PCSrc        = r.ex_src;
        bus_if.EX_ALUOut_0     = r.ex_alu;
        bus_if.EX_BranchTarget = r.ex_tgt;
    endtask

    task automatic compare(input string tag, input vec_t e);
        check({tag, ".IF_PC"}, bus_if.IF_PC, e.e_pc);
        check({tag, ".instr"}, bus_if.IF_ID_Instruction, e.e_valid ? imem(e.e_ia) : 32'h0);
        check({tag, ".pc_plus_4"}, bus_if.IF_ID_PC_plus_4, e.e_pp4);
        check({tag, ".valid"}, 32'(bus_if.IF_ID_valid), 32'(e.e_valid));
        check({tag, ".misaligned"}, 32'(bus_if.IF_misaligned), 32'(e.e_mis));
        check({tag, ".fetch_cnt"}, 32'(bus_if.perf_fetch_cnt), 32'(TB_CNT_W'(e.e_f)));
        check({tag, ".stall_cnt"}, 32'(bus_if.perf_stall_cnt), 32'(TB_CNT_W'(e.e_s)));
        check({tag, ".flush_cnt"}, 32'(bus_if.perf_flush_cnt), 32'(TB_CNT_W'(e.e_fl)));
    endtask

    initial begin
        vec_t seq_v, stall_v, e;

        //         pcw ifw fl clr id tgt            ex alu ex_tgt   e_pc           e_ia           e_pp4     vl ms  f  s  fl
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h4,         32'h0,         32'h4,    1, 0, 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h8,         32'h4,         32'h8,    1, 0, 2, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'hC,         32'h8,         32'hC,    1, 0, 3, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 2, 32'h100,      1, 1, 32'h40, 32'h40,        32'h0,         32'h0,    0, 0, 3, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h44,        32'h40,        32'h44,   1, 0, 4, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 2, 32'h20,       1, 0, 32'h80, 32'h20,        32'h44,        32'h48,   1, 0, 5, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 2, 32'h300,      0, 0, 0,      32'h20,        32'h44,        32'h48,   1, 0, 5, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 2, 32'h300,      0, 0, 0,      32'h20,        32'h44,        32'h48,   1, 0, 5, 2, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h24,        32'h20,        32'h24,   1, 0, 6, 2, 1));
        vecs.push_back(v(1, 1, 0, 0, 3, 32'h1003,     0, 0, 0,      32'h1000,      32'h24,        32'h28,   1, 1, 7, 2, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h1004,      32'h1000,      32'h1004, 1, 0, 8, 2, 1));
        vecs.push_back(v(1, 1, 0, 0, 5, 0,            0, 0, 0,      32'h8000_0180, 32'h1004,      32'h1008, 1, 0, 9, 2, 1));
        vecs.push_back(v(1, 0, 1, 0, 2, 32'h500,      1, 1, 32'h42, 32'h40,        32'h0,         32'h0,    0, 1, 9, 2, 2));
        vecs.push_back(v(0, 1, 1, 0, 2, 32'h7,        0, 0, 0,      32'h40,        32'h0,         32'h0,    0, 0, 9, 3, 3));
        vecs.push_back(v(1, 0, 0, 0, 0, 0,            0, 0, 0,      32'h44,        32'h0,         32'h0,    0, 0, 9, 3, 3));
        vecs.push_back(v(0, 1, 1, 1, 0, 0,            0, 0, 0,      32'h44,        32'h0,         32'h0,    0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h48,        32'h44,        32'h48,   1, 0, 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 2, 32'hFFFF_FFFC, 0, 0, 0,     32'hFFFF_FFFC, 32'h48,        32'h4C,   1, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0,            0, 0, 0,      32'h0,         32'hFFFF_FFFC, 32'h0,    1, 0, 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 2, 32'h88,       0, 0, 0,      32'h88,        32'h0,         32'h4,    1, 0, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 3, 32'h200,      0, 0, 0,      32'h88,        32'h0,         32'h4,    1, 0, 2, 1, 0));

        seq_v = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(seq_v);
        repeat (3) @(negedge clk);
        compare("reset", v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            sb_q.push_back(vecs[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            compare($sformatf("vec%0d", i), e);
        end

        // Asynchronous reset mid-stall at 0x88 with a JR redirect pending.
        #2 reset = 1'b1;
        #1;
        check("async_rst.IF_PC", bus_if.IF_PC, 32'h0);
        check("async_rst.valid", 32'(bus_if.IF_ID_valid), 32'h0);
        check("async_rst.pc_plus_4", bus_if.IF_ID_PC_plus_4, 32'h0);
        check("async_rst.stall_cnt", 32'(bus_if.perf_stall_cnt), 32'h0);
        @(negedge clk);
        check("rst_hold.IF_PC", bus_if.IF_PC, 32'h0);
        apply(seq_v);
        reset = 1'b0;
        @(negedge clk);
        compare("post_rst", v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 32'h4, 1, 0, 1, 0, 0));

        // Counter wrap: 255 stalled cycles reach the maximum, one more returns to zero.
        stall_v = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(stall_v);
        repeat (255) @(negedge clk);
        check("wrap.stall_max", 32'(bus_if.perf_stall_cnt), 32'd255);
        check("wrap.IF_PC_held", bus_if.IF_PC, 32'h4);
        @(negedge clk);
        check("wrap.stall_zero", 32'(bus_if.perf_stall_cnt), 32'd0);
        check("wrap.fetch_held", 32'(bus_if.perf_fetch_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
